// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer: state encodings, register offsets
// inside the 4-byte window, CTRL bit positions and the STATUS byte layout.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DONE   = 2'd2,
    ST_UNUSED = 2'd3
  } timer_state_e;

  localparam logic [1:0] CTRL_OFS     = 2'd0;
  localparam logic [1:0] INTERVAL_OFS = 2'd1;
  localparam logic [1:0] REMAIN_OFS   = 2'd2;
  localparam logic [1:0] STATUS_OFS   = 2'd3;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_PERIODIC_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT   = 2;

  function automatic logic [7:0] status_byte(input timer_state_e st,
                                             input logic ovr,
                                             input logic raise);
    return {4'b0000, st, ovr, raise};
  endfunction

endpackage

// File: rtl/Generic_counter.sv
// Free-running modulo-(CTR_MAX+1) counter. OUT_TRIG is a registered one-cycle
// pulse in the cycle after the count has sat at CTR_MAX.
module Generic_counter #(
  parameter int CTR_WIDTH = 4,
  parameter int CTR_MAX   = 9
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ENABLE,
  output logic OUT_TRIG
);

  localparam logic [CTR_WIDTH-1:0] MAX_V = CTR_MAX[CTR_WIDTH-1:0];

  logic [CTR_WIDTH-1:0] count_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q  <= '0;
      OUT_TRIG <= 1'b0;
    end else if (ENABLE) begin
      OUT_TRIG <= (count_q == MAX_V);
      if (count_q == MAX_V) count_q <= '0;
      else                  count_q <= count_q + 1'b1;
    end else begin
      OUT_TRIG <= 1'b0;
    end
  end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Memory-mapped interval timer: prescaled tick, programmable interval, one-shot
// or periodic expiry, and a level interrupt held until acknowledged.
module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int         PRESCALE_WIDTH = 17,
  parameter int         PRESCALE_MAX   = 99999,
  parameter logic [7:0] BASE_ADDR      = 8'hF0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic [7:0] BUS_DATA_IN,
  output logic [7:0] BUS_DATA_OUT,
  output logic       BUS_DATA_OE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  // Bus protocol: a write is a single-cycle BUS_WE strobe taking effect at the
  // closing edge; a read (BUS_WE=0 inside the window) is answered in the next
  // cycle with BUS_DATA_OE high for exactly that one cycle. No back-pressure.
  logic       in_win, wr_any, rd_any;
  logic [1:0] ofs;
  logic       ctrl_wr, interval_wr, restart_wr;
  logic       reload, disable_wr, tick, tick_ok, expiry, pre_reset;

  logic [2:0]   ctrl_q;
  logic [7:0]   interval_q, remain_q, remain_d, rd_mux;
  timer_state_e state_q, state_d;
  logic         raise_q, overrun_q;

  assign in_win      = (BUS_ADDR[7:2] == BASE_ADDR[7:2]);
  assign ofs         = BUS_ADDR[1:0];
  assign wr_any      = BUS_WE & in_win;
  assign rd_any      = ~BUS_WE & in_win;
  assign ctrl_wr     = wr_any & (ofs == CTRL_OFS);
  assign interval_wr = wr_any & (ofs == INTERVAL_OFS);
  assign restart_wr  = wr_any & (ofs == STATUS_OFS);
  assign disable_wr  = ctrl_wr & ~BUS_DATA_IN[CTRL_EN_BIT];
  assign reload      = (ctrl_wr & BUS_DATA_IN[CTRL_EN_BIT]) | (restart_wr & ctrl_q[CTRL_EN_BIT]);
  // Any bus write in the tick cycle swallows that tick.
  assign tick_ok     = tick & ~wr_any;
  assign pre_reset   = RESET | (state_q != ST_RUN) | reload;

  Generic_counter #(
    .CTR_WIDTH (PRESCALE_WIDTH),
    .CTR_MAX   (PRESCALE_MAX)
  ) u_prescaler (
    .CLK      (CLK),
    .RESET    (pre_reset),
    .ENABLE   (state_q == ST_RUN),
    .OUT_TRIG (tick)
  );

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    expiry   = 1'b0;
    if (disable_wr) begin
      state_d  = ST_IDLE;
      remain_d = 8'd0;
    end else if (reload) begin
      state_d  = ST_RUN;
      remain_d = interval_q;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tick_ok) begin
            // REMAIN=0 after a load of interval 0 wraps to 255, giving 256 ticks.
            if (remain_q == 8'd1) begin
              expiry = 1'b1;
              if (ctrl_q[CTRL_PERIODIC_BIT]) begin
                remain_d = interval_q;
              end else begin
                remain_d = 8'd0;
                state_d  = ST_DONE;
              end
            end else begin
              remain_d = remain_q - 8'd1;
            end
          end
        end
        ST_IDLE, ST_DONE: begin
        end
        default: begin
          state_d  = ST_IDLE;
          remain_d = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      remain_q   <= 8'd0;
      ctrl_q     <= 3'd0;
      interval_q <= 8'd1;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      if (ctrl_wr)     ctrl_q     <= BUS_DATA_IN[2:0];
      if (interval_wr) interval_q <= BUS_DATA_IN;
    end
  end

  // A new expiry beats a coincident ACK.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      raise_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (expiry && ctrl_q[CTRL_IRQ_EN_BIT]) begin
      raise_q <= 1'b1;
      if (raise_q && !BUS_INTERRUPT_ACK) overrun_q <= 1'b1;
    end else if (BUS_INTERRUPT_ACK) begin
      raise_q   <= 1'b0;
      overrun_q <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (ofs)
      CTRL_OFS:     rd_mux = {5'b00000, ctrl_q};
      INTERVAL_OFS: rd_mux = interval_q;
      REMAIN_OFS:   rd_mux = remain_q;
      STATUS_OFS:   rd_mux = status_byte(state_q, overrun_q, raise_q);
      default:      rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      BUS_DATA_OE  <= 1'b0;
      BUS_DATA_OUT <= 8'h00;
    end else begin
      BUS_DATA_OE  <= rd_any;
      BUS_DATA_OUT <= rd_any ? rd_mux : 8'h00;
    end
  end

  assign BUS_INTERRUPT_RAISE = raise_q;

endmodule
